// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier operand sequencer.
package booth_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int TIMEOUT_CYCLES = 48;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOADQ,
        LOADM,
        WAIT,
        CLEAR
    } state_t;

endpackage

// File: rtl/operand_fifo.sv
// Synchronous FIFO holding {m,q} operand pairs; occupancy is tracked by an explicit counter.
module operand_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    // Full/empty guards make a push-while-full or pop-while-empty a no-op.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // NOTE: storage has no reset; an entry is only read after it was written, and leaving it out keeps the array in plain RAM cells.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/booth_operand_sequencer.sv
// Feeds buffered operand pairs to the Booth core: start pulse, Q then M on data_in, waits for done or a watchdog, then clears.
module booth_operand_sequencer
    import booth_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [DATA_W-1:0]             op_m,
    input  logic [DATA_W-1:0]             op_q,
    output logic                          mul_start,
    output logic [DATA_W-1:0]             mul_data,
    output logic                          mul_clr,
    input  logic                          mul_done,
    output logic                          busy,
    output logic                          err_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_hold_m;
    logic [DATA_W-1:0]   r_hold_q;
    logic [WD_W-1:0]     r_wd;
    logic                r_err_timeout;
    logic                w_pop;
    logic                w_timeout;
    logic                w_full;
    logic                w_empty;
    logic [2*DATA_W-1:0] w_rdata;

    assign op_ready = !w_full && !rst;

    operand_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (op_valid && op_ready),
        .i_pop   (w_pop),
        .i_wdata ({op_m, op_q}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_cnt)
    );

    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_next_state = START;
                    w_pop        = 1'b1;
                end
            end
            START: w_next_state = LOADQ;
            LOADQ: w_next_state = LOADM;
            LOADM: w_next_state = WAIT;
            WAIT: begin
                // A done arriving on the last watchdog cycle still counts as success.
                if (mul_done) begin
                    w_next_state = CLEAR;
                end else if (r_wd == WD_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = CLEAR;
                end
            end
            CLEAR:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_hold_m      <= '0;
            r_hold_q      <= '0;
            r_wd          <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_hold_m <= w_rdata[2*DATA_W-1:DATA_W];
                r_hold_q <= w_rdata[DATA_W-1:0];
            end
            if (r_state == LOADM) begin
                r_wd <= '0;
            end else if (r_state == WAIT) begin
                r_wd <= r_wd + WD_ONE;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign mul_start   = (r_state == START);
    assign mul_clr     = (r_state == CLEAR);
    assign busy        = (r_state != IDLE);
    assign err_timeout = r_err_timeout;

    always_comb begin
        case (r_state)
            LOADQ:   mul_data = r_hold_q;
            LOADM:   mul_data = r_hold_m;
            default: mul_data = '0;
        endcase
    end

endmodule
